// File: rtl/mult_seq.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned, 2*WIDTH-bit product.
// Operands are reduced to magnitudes, multiplied over WIDTH cycles and sign-corrected once.
module mult_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               sign,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               flush,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

   state_e               state_q, state_d;
   logic [2*WIDTH-1:0]   ua_q, ua_d;
   logic [WIDTH-1:0]     ub_q, ub_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]     a_mag, b_mag;

   // The magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct unsigned.
   always_comb begin
      a_mag = (sign && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      b_mag = (sign && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
   end

   always_comb begin
      state_d  = state_q;
      ua_d     = ua_q;
      ub_d     = ub_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (start && !flush) begin
               ua_d    = {{WIDTH{1'b0}}, a_mag};
               ub_d    = b_mag;
               neg_d   = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               // ua_q is pre-shifted each step, so it always equals |a| << cnt.
               if (ub_q[0]) begin
                  acc_d = acc_q + ua_q;
               end
               ua_d  = ua_q << 1;
               ub_d  = ub_q >> 1;
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntLast) begin
                  state_d = StSign;
               end
            end
         end
         StSign: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               result_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
               state_d  = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         ua_q     <= '0;
         ub_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         ua_q     <= ua_d;
         ub_q     <= ub_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != StIdle);
   assign done   = (state_q == StDone);
   assign result = result_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: a 32-bit instance for the main scenarios and an 8-bit
// instance swept against a behavioural multiply.
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;

   logic        start32 = 1'b0, sign32 = 1'b0, flush32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        busy32, done32;
   logic [63:0] result32;

   logic        start8 = 1'b0, sign8 = 1'b0, flush8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] result8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mult_seq #(.WIDTH(32)) u_dut32 (
      .clk    (clk),
      .resetn (resetn),
      .start  (start32),
      .sign   (sign32),
      .a      (a32),
      .b      (b32),
      .flush  (flush32),
      .busy   (busy32),
      .done   (done32),
      .result (result32)
   );

   mult_seq #(.WIDTH(8)) u_dut8 (
      .clk    (clk),
      .resetn (resetn),
      .start  (start8),
      .sign   (sign8),
      .a      (a8),
      .b      (b8),
      .flush  (flush8),
      .busy   (busy8),
      .done   (done8),
      .result (result8)
   );

   // lat counts rising edges from the accepting edge up to the first cycle with done high.
   task automatic run32(input logic s, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [63:0] r);
      @(negedge clk);
      start32 = 1'b1; sign32 = s; a32 = x; b32 = y;
      @(negedge clk);
      start32 = 1'b0;
      lat = 1;
      while (!done32 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      r = result32;
   endtask

   task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y,
                       output int lat, output logic [15:0] r);
      @(negedge clk);
      start8 = 1'b1; sign8 = s; a8 = x; b8 = y;
      @(negedge clk);
      start8 = 1'b0;
      lat = 1;
      while (!done8 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      r = result8;
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || result32 !== 64'h0) begin
         n_fail++;
         $display("FAIL reset32: busy=%b done=%b result=%h, want 0 0 0", busy32, done32, result32);
      end
      n_checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 16'h0) begin
         n_fail++;
         $display("FAIL reset8: busy=%b done=%b result=%h, want 0 0 0", busy8, done8, result8);
      end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_vectors;
      logic        s_v [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] a_v [6] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
                               32'h80000000, 32'hFFFFFFFD};
      logic [31:0] b_v [6] = '{32'hFFFFFFFF, 32'h80000000, 32'd7, 32'd1, 32'd2, 32'hFFFFFFFB};
      logic [63:0] e_v [6] = '{64'hFFFFFFFE_00000001, 64'h40000000_00000000,
                               64'hFFFFFFFF_FFFFFFF9, 64'hFFFFFFFF_80000000,
                               64'h00000001_00000000, 64'h00000000_0000000F};
      int          lat;
      logic [63:0] r;
      for (int i = 0; i < 6; i++) begin
         run32(s_v[i], a_v[i], b_v[i], lat, r);
         n_checks++;
         if (r !== e_v[i]) begin
            n_fail++;
            $display("FAIL vec%0d result: got %h want %h", i, r, e_v[i]);
         end
         n_checks++;
         if (lat != 34) begin
            n_fail++;
            $display("FAIL vec%0d latency: got %0d want 34", i, lat);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a_v [3] = '{32'd3, 32'hFFFFFFFF, 32'h00010000};
      logic [31:0] b_v [3] = '{32'd5, 32'd2, 32'h00010000};
      logic [63:0] e_v [3] = '{64'd15, 64'h00000001_FFFFFFFE, 64'h00000001_00000000};
      int k = 0, cyc = 0, last = 0, idle = 0;
      @(negedge clk);
      start32 = 1'b1; sign32 = 1'b0; a32 = a_v[0]; b32 = b_v[0];
      while (k < 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (!busy32) idle++;
         if (done32) begin
            n_checks++;
            if (result32 !== e_v[k]) begin
               n_fail++;
               $display("FAIL b2b%0d result: got %h want %h", k, result32, e_v[k]);
            end
            if (k > 0) begin
               n_checks++;
               if (cyc - last != 35 || idle != 1) begin
                  n_fail++;
                  $display("FAIL b2b%0d spacing: got %0d cycles/%0d idle want 35/1",
                           k, cyc - last, idle);
               end
            end
            last = cyc;
            idle = 0;
            k++;
            if (k < 3) begin
               a32 = a_v[k]; b32 = b_v[k];
            end
         end
      end
      start32 = 1'b0;
      n_checks++;
      if (k != 3) begin
         n_fail++;
         $display("FAIL b2b count: got %0d ops want 3", k);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_flush;
      int          lat;
      logic [63:0] r;
      int          seen_done = 0;
      run32(1'b0, 32'h1234, 32'd1, lat, r);
      @(negedge clk);
      start32 = 1'b1; sign32 = 1'b0; a32 = 32'hFFFF; b32 = 32'hFFFF;
      @(negedge clk);
      start32 = 1'b0;
      repeat (9) @(negedge clk);
      flush32 = 1'b1;
      @(negedge clk);
      flush32 = 1'b0;
      n_checks++;
      if (busy32 !== 1'b0) begin
         n_fail++;
         $display("FAIL flush busy: got %b want 0", busy32);
      end
      repeat (40) begin
         @(negedge clk);
         if (done32) seen_done++;
      end
      n_checks++;
      if (seen_done != 0 || result32 !== 64'h1234) begin
         n_fail++;
         $display("FAIL flush hold: done pulses %0d result %h want 0 and 1234", seen_done,
                  result32);
      end
      // start together with flush in IDLE must be rejected
      @(negedge clk);
      start32 = 1'b1; flush32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0; flush32 = 1'b0;
      n_checks++;
      if (busy32 !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_start busy: got %b want 0", busy32);
      end
      run32(1'b0, 32'hFFFF, 32'hFFFF, lat, r);
      n_checks++;
      if (r !== 64'hFFFE0001 || lat != 34) begin
         n_fail++;
         $display("FAIL flush recover: got %h lat %0d want fffe0001 lat 34", r, lat);
      end
   endtask

   task automatic test_reset_mid;
      int          lat;
      logic [63:0] r;
      int          seen_done = 0;
      @(negedge clk);
      start32 = 1'b1; sign32 = 1'b0; a32 = 32'd100; b32 = 32'd100;
      @(negedge clk);
      start32 = 1'b0;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1;
      n_checks++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || result32 !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b done=%b result=%h want 0 0 0", busy32, done32,
                  result32);
      end
      @(negedge clk);
      resetn = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (done32) seen_done++;
      end
      n_checks++;
      if (seen_done != 0) begin
         n_fail++;
         $display("FAIL reset_mid done: got %0d pulses want 0", seen_done);
      end
      run32(1'b1, 32'hFFFFFFF6, 32'd10, lat, r);
      n_checks++;
      if (r !== 64'hFFFFFFFF_FFFFFF9C || lat != 34) begin
         n_fail++;
         $display("FAIL reset_mid recover: got %h lat %0d want ffffffffffffff9c lat 34", r, lat);
      end
   endtask

   task automatic test_width8;
      logic        s_v [3] = '{1'b1, 1'b0, 1'b1};
      logic [7:0]  a_v [3] = '{8'h80, 8'hFF, 8'h80};
      logic [7:0]  b_v [3] = '{8'h80, 8'hFF, 8'h7F};
      logic [15:0] e_v [3] = '{16'h4000, 16'hFE01, 16'hC080};
      int          lat;
      logic [15:0] r, e;
      logic signed [15:0] sp;
      logic        s;
      logic [7:0]  x, y;
      for (int i = 0; i < 3; i++) begin
         run8(s_v[i], a_v[i], b_v[i], lat, r);
         n_checks++;
         if (r !== e_v[i] || lat != 10) begin
            n_fail++;
            $display("FAIL w8 vec%0d: got %h lat %0d want %h lat 10", i, r, lat, e_v[i]);
         end
      end
      for (int i = 0; i < 2000; i++) begin
         s = 1'($urandom_range(0, 1));
         x = 8'($urandom);
         y = 8'($urandom);
         if (s) begin
            sp = $signed(x) * $signed(y);
            e  = sp;
         end else begin
            e = {8'b0, x} * {8'b0, y};
         end
         run8(s, x, y, lat, r);
         n_checks++;
         if (r !== e || lat != 10) begin
            n_fail++;
            $display("FAIL w8 rand%0d s=%b a=%h b=%h: got %h lat %0d want %h lat 10",
                     i, s, x, y, r, lat, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_width8();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
